deskew_frame_loader: RTL
========================

DESKEW_FRAME_LOADER -- requirements
Module: deskew_frame_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, pixel and memory data width.
REQ-002 SHALL have parameter PIXELS, default 784, pixels per frame (28x28).
REQ-003 SHALL have parameter OUT_BASE, default 784, memory address of the first result pixel.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  input pixel valid.
REQ-007 s_ready  output  1  loader accepts an input pixel.
REQ-008 s_data  input  WIDTH  input pixel, Q2.14 intensity.
REQ-009 m_valid  output  1  result pixel valid.
REQ-010 m_ready  input  1  downstream accepts a result pixel.
REQ-011 m_data  output  WIDTH  deskewed pixel.
REQ-012 m_last  output  1  marks result pixel PIXELS-1.
REQ-013 desk_start  output  1  start pulse to the deskew engine.
REQ-014 desk_ready  input  1  deskew engine idle flag.
REQ-015 mem_sel  output  1  1 routes the shared BRAM port to the deskew engine; 0 routes it to this block.
REQ-016 address  output  11  BRAM address.
REQ-017 out_data  output  WIDTH  BRAM write data.
REQ-018 in_data  input  WIDTH  BRAM read data, valid one cycle after the address/en cycle.
REQ-019 en / we  output  1 each  BRAM enable and write enable.
REQ-020 frame_done  output  1  one-cycle pulse on the last output handshake.

Function
REQ-021 The FSM SHALL use the states LOAD, KICK, WAIT_BUSY, WAIT_DONE, RD, RD_DATA, SEND, and SHALL hold an 11-bit pixel counter cnt.
- LOAD: s_ready=1, en=we=(s_valid), address=cnt, out_data=s_data.
 - On each handshake: cnt++.
 - On the handshake with cnt==PIXELS-1: cnt<=0 and go to KICK.
- KICK: if desk_ready=1, desk_start=1 for exactly 1 cycle and go to WAIT_BUSY; otherwise stay.
- WAIT_BUSY: mem_sel=1; go to WAIT_DONE when desk_ready=0.
- WAIT_DONE: mem_sel=1; go to RD when desk_ready=1.
- RD: en=1, we=0, address=OUT_BASE+cnt.
- RD_DATA: latch in_data into pix_reg.
- SEND: m_valid=1, m_data=pix_reg, m_last=(cnt==PIXELS-1).
 - On m_ready: if last, frame_done=1, cnt<=0 and go to LOAD; otherwise cnt++ and go to RD.
REQ-022 s_ready, m_valid and desk_start SHALL be 0 in every state not named for them in REQ-021.
REQ-023 All outputs SHALL be Moore/state-decoded, except that en, we and out_data in LOAD may follow s_valid and s_data.
REQ-024 Latency: desk_ready sampled high in WAIT_DONE at cycle t SHALL produce m_valid=1 at cycle t+3.
REQ-025 Once asserted, m_valid SHALL remain 1, with m_data and m_last stable, until m_ready=1.
REQ-026 Throughput SHALL be one result pixel per 3 cycles when m_ready is held 1.
REQ-027 address SHALL wrap only within 11 bits; OUT_BASE+PIXELS-1=1567 SHALL NOT overflow.
REQ-028 While mem_sel=1, en, we, address and out_data SHALL be 0.
REQ-029 s_data SHALL NOT be written while mem_sel=1.
REQ-030 In LOAD, an idle s_valid=0 cycle SHALL leave cnt unchanged and keep we=0.
REQ-031 A desk_ready glitch high during WAIT_BUSY SHALL be ignored; only 1->0->1 completes.

Reset
REQ-032 On reset=0, the block SHALL immediately enter LOAD, set cnt=0 and pix_reg=0.
REQ-033 During reset, all outputs SHALL be 0, except s_ready, which SHALL be 1 after reset release.
REQ-034 Reset mid-frame SHALL discard partial input and output; the next frame SHALL start at address 0.

Structure
REQ-035 The state enum, PIXELS, IMG_DIM=28 and OUT_BASE SHALL live in shared package deskew_pkg.
REQ-036 No sub-module SHALL be used; the counter and FSM SHALL be inline, with one always_ff and one always_comb.

Verification
REQ-037 Stream pixels 0..783 with value=index and s_valid held 1 -> BRAM[k]=k, desk_start pulses once at the cycle after beat 783.
REQ-038 Deskew model drops desk_ready 1 cycle after start and raises it 500 cycles later -> mem_sel=1 for exactly that window, then m_valid 3 cycles later.
REQ-039 Preload BRAM[784+k]=k^0x5A5A, m_ready=1 -> 784 outputs in order, m_last and frame_done only on beat 783, 3 cycles per beat.
REQ-040 Random m_ready (50%) -> m_data stable while stalled, no pixel lost or duplicated.
REQ-041 Assert reset at load beat 400, then send a full frame -> writes restart at address 0, exactly one desk_start.
REQ-042 Hold desk_ready=0 in KICK for 20 cycles -> desk_start stays 0 until desk_ready=1, then pulses for one cycle.

Source files
------------

// File: rtl/deskew_pkg.sv
// Shared constants and FSM state encoding for the deskew frame loader.
package deskew_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned IMG_DIM  = 28;
    localparam int unsigned PIXELS   = IMG_DIM * IMG_DIM;
    localparam int unsigned OUT_BASE = 784;

    typedef enum logic [2:0] {
        LOAD,
        KICK,
        WAIT_BUSY,
        WAIT_DONE,
        RD,
        RD_DATA,
        SEND
    } state_t;

endpackage

// File: rtl/deskew_frame_loader_if.sv
// Pixel streams, deskew-engine handshake and shared BRAM port of the frame loader.
interface deskew_frame_loader_if #(
    parameter int unsigned WIDTH = 16
);
    import deskew_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [WIDTH-1:0]  s_data;
    logic              m_valid;
    logic              m_ready;
    logic [WIDTH-1:0]  m_data;
    logic              m_last;
    logic              desk_start;
    logic              desk_ready;
    logic              mem_sel;
    logic [ADDR_W-1:0] address;
    logic [WIDTH-1:0]  out_data;
    logic [WIDTH-1:0]  in_data;
    logic              en;
    logic              we;
    logic              frame_done;

    modport master (
        input  s_valid, s_data, m_ready, desk_ready, in_data,
        output s_ready, m_valid, m_data, m_last, desk_start, mem_sel,
               address, out_data, en, we, frame_done
    );

    modport slave (
        output s_valid, s_data, m_ready, desk_ready, in_data,
        input  s_ready, m_valid, m_data, m_last, desk_start, mem_sel,
               address, out_data, en, we, frame_done
    );

endinterface

// File: rtl/deskew_frame_loader.sv
// Loads a frame into BRAM, hands the BRAM to the deskew engine, then streams
// the deskewed result back out one pixel per three cycles.
module deskew_frame_loader #(
    parameter int unsigned WIDTH    = deskew_pkg::DATA_W,
    parameter int unsigned PIXELS   = deskew_pkg::PIXELS,
    parameter int unsigned OUT_BASE = deskew_pkg::OUT_BASE
) (
    input  logic                   clk,
    input  logic                   reset,
    deskew_frame_loader_if.master  bus
);
    import deskew_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PIXELS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(OUT_BASE);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]  r_pix;
    logic [WIDTH-1:0]  w_pix_nxt;
    logic              w_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_pix   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pix   <= w_pix_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pix_nxt      = r_pix;
        w_last         = (r_cnt == LAST_IDX);
        bus.s_ready    = 1'b0;
        bus.m_valid    = 1'b0;
        bus.m_data     = '0;
        bus.m_last     = 1'b0;
        bus.desk_start = 1'b0;
        bus.mem_sel    = 1'b0;
        bus.address    = '0;
        bus.out_data   = '0;
        bus.en         = 1'b0;
        bus.we         = 1'b0;
        bus.frame_done = 1'b0;

        case (r_state)
            LOAD: begin
                bus.s_ready  = 1'b1;
                bus.en       = bus.s_valid;
                bus.we       = bus.s_valid;
                bus.address  = r_cnt;
                bus.out_data = bus.s_data;
                if (bus.s_valid) begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = KICK;
                    end else begin
                        w_cnt_nxt = r_cnt + ADDR_W'(1);
                    end
                end
            end
            KICK: begin
                if (bus.desk_ready) begin
                    bus.desk_start = 1'b1;
                    w_state_nxt    = WAIT_BUSY;
                end
            end
            // Engine must first drop desk_ready; a stale high here means it has not started.
            WAIT_BUSY: begin
                bus.mem_sel = 1'b1;
                if (!bus.desk_ready) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                bus.mem_sel = 1'b1;
                if (bus.desk_ready) w_state_nxt = RD;
            end
            RD: begin
                bus.en      = 1'b1;
                bus.address = BASE + r_cnt;
                w_state_nxt = RD_DATA;
            end
            RD_DATA: begin
                w_pix_nxt   = bus.in_data;
                w_state_nxt = SEND;
            end
            SEND: begin
                bus.m_valid = 1'b1;
                bus.m_data  = r_pix;
                bus.m_last  = w_last;
                if (bus.m_ready) begin
                    if (w_last) begin
                        bus.frame_done = 1'b1;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = LOAD;
                    end else begin
                        w_cnt_nxt   = r_cnt + ADDR_W'(1);
                        w_state_nxt = RD;
                    end
                end
            end
            default: w_state_nxt = LOAD;
        endcase

        // Outputs stay quiet for the whole reset assertion, including s_ready.
        if (!reset) begin
            bus.s_ready    = 1'b0;
            bus.m_valid    = 1'b0;
            bus.m_data     = '0;
            bus.m_last     = 1'b0;
            bus.desk_start = 1'b0;
            bus.mem_sel    = 1'b0;
            bus.address    = '0;
            bus.out_data   = '0;
            bus.en         = 1'b0;
            bus.we         = 1'b0;
            bus.frame_done = 1'b0;
        end
    end

endmodule
